fetch_stage: RTL
================

# fetch_stage

Instruction-fetch stage of the 5-stage RISC-V pipeline, feeding the decode stage. It holds the PC and issues instruction-memory reads over a req/ack handshake. Responses go into a 2-entry prefetch buffer, and the IF/ID pipeline register is loaded from that buffer. It consumes the decode stage's `IFWrite`, `Branch`, `Jump` and `JumpAddr`, and produces `Instruction_id`, `PC_id` and `Valid_id`.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `NOP_INSTR`, 32'h0000_0013, bubble instruction (`addi x0,x0,0`).

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  synchronous, active-high.
- `IFWrite`  in  1  0 = decode stalled; hold IF/ID and ignore redirects.
- `Branch`  in  1  taken branch resolved in decode.
- `Jump`  in  1  JAL/JALR in decode.
- `JumpAddr`  in  32  redirect target.
- `imem_req`  out  1  read request.
- `imem_addr`  out  32  word address of the request.
- `imem_ack`  in  1  response valid; may be high in the same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction, valid when `imem_ack`=1.
- `Instruction_id`  out  32  IF/ID instruction.
- `PC_id`  out  32  IF/ID PC.
- `Valid_id`  out  1  1 = `Instruction_id` is a real fetched instruction.

## Operation
- Handshake: once `imem_req` rises, it and `imem_addr` stay constant until the cycle with `imem_ack`=1. At most one request is outstanding. `imem_ack` without `imem_req` is ignored.
- `fetch_pc` register: increments by 4 on each accepted response in the FETCH state. It is loaded with `JumpAddr` on a redirect.
- FSM states:
  - FETCH: `imem_req` = (buffer count < 2) or a request is already in progress; `imem_addr` = `fetch_pc`. On ack, push {`fetch_pc`, `imem_rdata`} into the buffer.
  - DRAIN: `imem_req` = 1 at the stale address. On ack, discard the data and go to FETCH.
- Redirect = (`Branch` | `Jump`) & `IFWrite`. In the redirect cycle:
  - flush the buffer (any same-cycle push is dropped);
  - `fetch_pc` ← `JumpAddr`;
  - IF/ID ← {`NOP_INSTR`, `PC_id` unchanged, `Valid_id`=0};
  - if `imem_req`=1 and `imem_ack`=0, go to DRAIN; otherwise stay in FETCH.
- A redirect while already in DRAIN updates `fetch_pc` and stays in DRAIN.
- `Branch`/`Jump` while `IFWrite`=0 are ignored. Decode re-evaluates them after the stall clears.
- IF/ID update with `IFWrite`=1 and no redirect:
  - buffer non-empty: pop the head into {`PC_id`, `Instruction_id`} and set `Valid_id`=1;
  - buffer empty: load `NOP_INSTR` and set `Valid_id`=0.
- `IFWrite`=0: IF/ID holds and nothing is popped. Fetching continues until the buffer is full.
- Simultaneous push and pop with count=2 is legal, because `imem_req` was only issued while count < 2.
- `fetch_pc` wraps modulo 2^32. Bits [1:0] are passed through unmodified (no alignment check).

## Timing
- Reset values: `fetch_pc`=`RESET_PC`, state FETCH, buffer empty, `Instruction_id`=`NOP_INSTR`, `PC_id`=`RESET_PC`, `Valid_id`=0.
- `imem_req`=0 while `reset`=1. An outstanding request is abandoned by reset; the memory shares the same reset.
- Fetch latency: address in cycle t, zero-wait ack in t → buffer at the end of t → IF/ID at the end of t+1 → visible in decode in cycle t+2.
- Redirect penalty, zero-wait memory: redirect in cycle t → `JumpAddr` on `imem_addr` in t+1 → target in `Instruction_id` in t+3. Exactly 2 bubbles (`Valid_id`=0) appear in t+1 and t+2.
- Steady state with zero-wait memory and `IFWrite`=1: one instruction per cycle.
- Outputs are registered, except `imem_req`/`imem_addr`, which are decoded from registered state and the buffer count. There is no combinational path from `imem_ack` to `imem_req`.

## Structure
- Shared package `cpu_pkg`: `NOP_INSTR`, `RESET_PC` default, and the fetch FSM state enum.
- Sub-module `fetch_fifo`: 2-entry FIFO of {pc[31:0], instr[31:0]} with push, pop, flush and count. Flush has priority over push.
- `fetch_stage` itself holds the FSM, `fetch_pc` and the IF/ID register.

## Test plan
- Reset then zero-wait memory returning `imem_rdata`=addr: `imem_addr` = 0, 4, 8, …; `PC_id`=0 with `Valid_id`=1 in cycle 2; then one instruction per cycle.
- Memory ack delayed 3 cycles: `imem_req`/`imem_addr` held stable for 3 cycles; bubbles with `Valid_id`=0 between instructions; no duplicate PCs.
- `IFWrite`=0 for 4 cycles: `Instruction_id` and `PC_id` frozen; at most 2 further requests, then `imem_req`=0; no loss or duplication on release.
- `Jump`=1, `JumpAddr`=0x100 while a request to 0x10 is pending: ack for 0x10 discarded; next `imem_addr`=0x100; next valid `PC_id`=0x100.
- `Branch`=1 together with `IFWrite`=0: no redirect and no flush; a later `Branch`=1 with `IFWrite`=1 redirects with exactly 2 bubbles.
- `reset` asserted mid-request: next cycle `imem_req`=0 and `Valid_id`=0; after release, fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the pipeline front end
package cpu_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0013;

   typedef enum logic {
      FETCH_S = 1'b0,
      DRAIN_S = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry prefetch buffer of {pc, instr}; flush beats push
module fetch_fifo
   import cpu_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t push_data,
   output fetch_entry_t head_data,
   output logic [1:0]   count
);

   fetch_entry_t mem_q [2];
   fetch_entry_t mem_d [2];
   logic         rd_ptr_q, rd_ptr_d;
   logic         wr_ptr_q, wr_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         do_push, do_pop;

   // Pointer/count bookkeeping; a pop frees the slot a same-cycle push may reuse
   always_comb begin
      do_pop   = pop && (count_q != 2'd0);
      do_push  = push && ((count_q != 2'd2) || do_pop);
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset since count guards every read
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, imem req/ack FSM, prefetch buffer and IF/ID register
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        IFWrite,
   input  logic        Branch,
   input  logic        Jump,
   input  logic [31:0] JumpAddr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instruction_id,
   output logic [31:0] PC_id,
   output logic        Valid_id
);

   fetch_state_e state_q, state_d;
   logic [31:0]  fetch_pc_q, fetch_pc_d;
   logic [31:0]  drain_addr_q, drain_addr_d;
   logic         req_active_q, req_active_d;
   logic [31:0]  instr_id_q, instr_id_d;
   logic [31:0]  pc_id_q, pc_id_d;
   logic         valid_id_q, valid_id_d;

   logic         redirect;
   logic         push;
   logic         pop;
   fetch_entry_t fifo_in;
   fetch_entry_t fifo_head;
   logic [1:0]   fifo_count;

   // Redirect only counts when decode is not stalled; responses land only while in FETCH
   always_comb begin
      redirect = (Branch | Jump) & IFWrite;
      push     = imem_req & imem_ack & (state_q == FETCH_S);
      pop      = IFWrite & ~redirect;
      fifo_in  = '{pc: fetch_pc_q, instr: imem_rdata};
   end

   fetch_fifo u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .flush     (redirect),
      .push_data (fifo_in),
      .head_data (fifo_head),
      .count     (fifo_count)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH_S;
      end else begin
         state_q <= state_d;
      end
   end

   // A redirect with an unanswered request must wait out that request in DRAIN
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH_S: begin
            if (redirect && imem_req && !imem_ack) begin
               state_d = DRAIN_S;
            end
         end
         DRAIN_S: begin
            if (imem_ack) begin
               state_d = FETCH_S;
            end
         end
         default: state_d = FETCH_S;
      endcase
   end

   // Request decode from registered state only, so ack never loops back into req
   always_comb begin
      imem_req  = 1'b0;
      imem_addr = fetch_pc_q;
      case (state_q)
         FETCH_S: begin
            imem_req  = (fifo_count < 2'd2) | req_active_q;
            imem_addr = fetch_pc_q;
         end
         DRAIN_S: begin
            imem_req  = 1'b1;
            imem_addr = drain_addr_q;
         end
         default: begin
            imem_req  = 1'b0;
            imem_addr = fetch_pc_q;
         end
      endcase
      if (reset) begin
         imem_req = 1'b0;
      end
   end

   // PC advance, stale-address capture and IF/ID load/bubble/hold selection
   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      drain_addr_d = drain_addr_q;
      req_active_d = imem_req & ~imem_ack;
      instr_id_d   = instr_id_q;
      pc_id_d      = pc_id_q;
      valid_id_d   = valid_id_q;

      if (state_q == FETCH_S) begin
         drain_addr_d = fetch_pc_q;
      end

      if (redirect) begin
         fetch_pc_d = JumpAddr;
      end else if (push) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end

      if (redirect) begin
         instr_id_d = NOP_INSTR;
         valid_id_d = 1'b0;
      end else if (IFWrite) begin
         if (fifo_count != 2'd0) begin
            pc_id_d    = fifo_head.pc;
            instr_id_d = fifo_head.instr;
            valid_id_d = 1'b1;
         end else begin
            instr_id_d = NOP_INSTR;
            valid_id_d = 1'b0;
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q   <= RESET_PC;
         drain_addr_q <= RESET_PC;
         req_active_q <= 1'b0;
         instr_id_q   <= NOP_INSTR;
         pc_id_q      <= RESET_PC;
         valid_id_q   <= 1'b0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         drain_addr_q <= drain_addr_d;
         req_active_q <= req_active_d;
         instr_id_q   <= instr_id_d;
         pc_id_q      <= pc_id_d;
         valid_id_q   <= valid_id_d;
      end
   end

   assign Instruction_id = instr_id_q;
   assign PC_id          = pc_id_q;
   assign Valid_id       = valid_id_q;

endmodule
